// File: rtl/sd_stream_scheduler.sv
// sd_stream_scheduler: refills the audio FIFO from SD card block reads.
// Once a song is started, it issues one block read whenever the FIFO has
// room for a whole block. SD bytes are forwarded to the FIFO with one cycle
// of latency, and the block reads are sequenced until the song ends or is
// stopped.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, stop               one-cycle control pulses from the menu FSM
//   song_base_addr/num_blocks song descriptor, sampled on an accepted start
//   fifo_count, fifo_full     audio FIFO status
//   sd_ready, sd_rd, sd_addr  SD read request handshake
//   sd_data_valid, sd_dout,
//   sd_done                   SD byte stream and end-of-block pulse
//   fifo_wr, fifo_din         audio FIFO write port
//   busy, song_done           status (busy is high outside IDLE)
//   overflow_err, len_err     sticky errors, cleared by the next start
module sd_stream_scheduler #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned FIFO_DEPTH  = 2048,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LEN_W       = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [ADDR_W-1:0]             song_base_addr,
  input  logic [LEN_W-1:0]              song_num_blocks,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          fifo_full,
  input  logic                          sd_ready,
  output logic                          sd_rd,
  output logic [ADDR_W-1:0]             sd_addr,
  input  logic                          sd_data_valid,
  input  logic [7:0]                    sd_dout,
  input  logic                          sd_done,
  output logic                          fifo_wr,
  output logic [7:0]                    fifo_din,
  output logic                          busy,
  output logic                          song_done,
  output logic                          overflow_err,
  output logic                          len_err
);

  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BCNT_W = $clog2(BLOCK_BYTES + 1) + 1;
  localparam logic [FCNT_W-1:0] ROOM_LIMIT = FCNT_W'(FIFO_DEPTH - BLOCK_BYTES);
  localparam logic [BCNT_W-1:0] BLOCK_LEN  = BCNT_W'(BLOCK_BYTES);
  localparam logic [BCNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_STREAM, S_ABORT, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    block_idx_q;
  logic [BCNT_W-1:0]   byte_cnt_q;
  logic [BCNT_W-1:0]   byte_cnt_eff;

  logic                accept;
  logic                strobe;
  logic                room;

  logic                sd_rd_d;
  logic [ADDR_W-1:0]   sd_addr_d;
  logic                fifo_wr_d;
  logic [7:0]          fifo_din_d;
  logic                busy_d;
  logic                song_done_d;
  logic                overflow_err_d;
  logic                len_err_d;

  assign accept = (state_q == S_IDLE) && start && !stop;
  assign strobe = (state_q == S_STREAM) && sd_data_valid;
  assign room   = (fifo_count <= ROOM_LIMIT);

  // Byte count including a byte strobed in this same cycle; saturates so
  // runaway blocks can never wrap back to a legal length.
  assign byte_cnt_eff = (strobe && (byte_cnt_q != CNT_MAX)) ?
                        byte_cnt_q + BCNT_W'(1) : byte_cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (song_num_blocks == '0) ? S_FINISH : S_CHECK;
      S_CHECK: begin
        if (stop)                        state_d = S_IDLE;
        else if (block_idx_q == len_q)   state_d = S_FINISH;
        else if (room && sd_ready)       state_d = S_ISSUE;
      end
      // The read is already on the wire, so a stop here must drain the block.
      S_ISSUE:  state_d = stop ? S_ABORT : S_STREAM;
      S_STREAM: begin
        if (sd_done && stop) state_d = S_IDLE;
        else if (sd_done)    state_d = S_CHECK;
        else if (stop)       state_d = S_ABORT;
      end
      S_ABORT:  if (sd_done) state_d = S_IDLE;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output next-values, aligned with the state they belong to
  always_comb begin
    sd_rd_d        = (state_d == S_ISSUE);
    sd_addr_d      = sd_addr;
    if (sd_rd_d) sd_addr_d = base_q + ADDR_W'(block_idx_q);
    fifo_wr_d      = strobe && !fifo_full;
    fifo_din_d     = fifo_din;
    if (fifo_wr_d) fifo_din_d = sd_dout;
    busy_d         = (state_d != S_IDLE);
    song_done_d    = (state_d == S_FINISH);
    overflow_err_d = overflow_err || (strobe && fifo_full);
    len_err_d      = len_err ||
                     ((state_q == S_STREAM) && sd_done && (byte_cnt_eff != BLOCK_LEN));
    if (accept) begin
      overflow_err_d = 1'b0;
      len_err_d      = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sd_rd        <= 1'b0;
      sd_addr      <= '0;
      fifo_wr      <= 1'b0;
      fifo_din     <= '0;
      busy         <= 1'b0;
      song_done    <= 1'b0;
      overflow_err <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      sd_rd        <= sd_rd_d;
      sd_addr      <= sd_addr_d;
      fifo_wr      <= fifo_wr_d;
      fifo_din     <= fifo_din_d;
      busy         <= busy_d;
      song_done    <= song_done_d;
      overflow_err <= overflow_err_d;
      len_err      <= len_err_d;
    end
  end

  // Song descriptor, block index and per-block byte counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q      <= '0;
      len_q       <= '0;
      block_idx_q <= '0;
      byte_cnt_q  <= '0;
    end else begin
      if (accept) begin
        base_q      <= song_base_addr;
        len_q       <= song_num_blocks;
        block_idx_q <= '0;
      end else if ((state_q == S_STREAM) && sd_done) begin
        block_idx_q <= block_idx_q + LEN_W'(1);
      end
      if (state_q == S_ISSUE) byte_cnt_q <= '0;
      else                    byte_cnt_q <= byte_cnt_eff;
    end
  end

endmodule

// File: tb/tb_sd_stream_scheduler.sv
// Testbench for sd_stream_scheduler (BLOCK_BYTES=4, FIFO_DEPTH=16).
// Expected FIFO bytes and SD addresses are queued as stimulus is driven and
// popped by a negedge monitor when the DUT writes or requests.
module tb_sd_stream_scheduler;

  localparam int unsigned BB = 4;
  localparam int unsigned FD = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop;
  logic [AW-1:0] song_base_addr;
  logic [LW-1:0] song_num_blocks;
  logic [4:0]    fifo_count;
  logic          fifo_full, sd_ready;
  logic          sd_rd;
  logic [AW-1:0] sd_addr;
  logic          sd_data_valid;
  logic [7:0]    sd_dout;
  logic          sd_done;
  logic          fifo_wr;
  logic [7:0]    fifo_din;
  logic          busy, song_done, overflow_err, len_err;

  always #5 clk = ~clk;

  sd_stream_scheduler #(.BLOCK_BYTES(BB), .FIFO_DEPTH(FD), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .song_base_addr(song_base_addr), .song_num_blocks(song_num_blocks),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .sd_ready(sd_ready),
    .sd_rd(sd_rd), .sd_addr(sd_addr), .sd_data_valid(sd_data_valid),
    .sd_dout(sd_dout), .sd_done(sd_done), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .busy(busy), .song_done(song_done), .overflow_err(overflow_err), .len_err(len_err)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;
  int done_count = 0;

  logic [7:0]    byte_q[$];
  logic [AW-1:0] addr_q[$];
  logic          strobe_pending = 1'b0;
  logic          wr_exp = 1'b0;
  logic          prev_rd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge
  always @(negedge clk) begin
    chk("fifo_wr_timing", 64'(fifo_wr), 64'(wr_exp));
    if (fifo_wr) begin
      wr_count++;
      chk("fifo_wr_expected", 64'(byte_q.size() != 0), 64'd1);
      if (byte_q.size() != 0) chk("fifo_din", 64'(fifo_din), 64'(byte_q.pop_front()));
    end
    if (sd_rd) begin
      rd_count++;
      chk("sd_rd_one_cycle", 64'(prev_rd), 64'd0);
      chk("sd_rd_expected", 64'(addr_q.size() != 0), 64'd1);
      if (addr_q.size() != 0) chk("sd_addr", 64'(sd_addr), 64'(addr_q.pop_front()));
    end
    prev_rd = sd_rd;
    if (song_done) done_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_exp = strobe_pending;
    strobe_pending = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic full, input logic expw);
    sd_data_valid = 1'b1;
    sd_dout = b;
    fifo_full = full;
    strobe_pending = expw;
    if (expw) byte_q.push_back(b);
    step();
    sd_data_valid = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic pulse_done();
    sd_done = 1'b1;
    step();
    sd_done = 1'b0;
  endtask

  task automatic start_song(input logic [AW-1:0] base, input logic [LW-1:0] len);
    song_base_addr = base;
    song_num_blocks = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_rd();
    int n = 0;
    while (!sd_rd && n < 20) begin step(); n++; end
    chk("sd_rd_wait", 64'(sd_rd), 64'd1);
  endtask

  task automatic wait_song_done();
    int n = 0;
    while (!song_done && n < 20) begin step(); n++; end
    chk("song_done_wait", 64'(song_done), 64'd1);
  endtask

  // One full block: request, then nbytes bytes, then sd_done
  task automatic run_block(input int nbytes, input logic [7:0] first);
    wait_rd();
    step();
    for (int i = 0; i < nbytes; i++) send_byte(first + 8'(i), 1'b0, 1'b1);
    pulse_done();
  endtask

  initial begin
    int w0, r0, d0;
    rst = 1'b0; start = 0; stop = 0; song_base_addr = '0; song_num_blocks = '0;
    fifo_count = '0; fifo_full = 0; sd_ready = 1; sd_data_valid = 0; sd_dout = '0; sd_done = 0;
    #3;
    chk("rst_sd_rd", 64'(sd_rd), 0);
    chk("rst_sd_addr", 64'(sd_addr), 0);
    chk("rst_fifo_wr", 64'(fifo_wr), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_song_done", 64'(song_done), 0);
    chk("rst_errs", 64'({overflow_err, len_err}), 0);
    @(posedge clk); #1; rst = 1'b1;
    step();

    // 1: two-block song
    w0 = wr_count; d0 = done_count;
    addr_q.push_back(32'h100); addr_q.push_back(32'h101);
    start_song(32'h100, 24'd2);
    chk("t1_busy", 64'(busy), 1);
    run_block(4, 8'h10);
    run_block(4, 8'h20);
    wait_song_done();
    chk("t1_busy_at_done", 64'(busy), 1);
    step();
    chk("t1_busy_after", 64'(busy), 0);
    chk("t1_song_done_pulse", 64'(song_done), 0);
    chk("t1_writes", 64'(wr_count - w0), 8);
    chk("t1_done_count", 64'(done_count - d0), 1);
    chk("t1_addr_drained", 64'(addr_q.size()), 0);

    // 2: FIFO room gating
    fifo_count = 5'd13;
    r0 = rd_count;
    addr_q.push_back(32'h180);
    start_song(32'h180, 24'd1);
    step(); step(); step();
    chk("t2_held", 64'(rd_count - r0), 0);
    fifo_count = 5'd12;
    step();
    chk("t2_rd_after_room", 64'(sd_rd), 1);
    step();
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b0, 1'b1);
    pulse_done();
    wait_song_done();
    fifo_count = '0;
    step();

    // 3: stop mid-block
    d0 = done_count; w0 = wr_count;
    addr_q.push_back(32'h200);
    start_song(32'h200, 24'd1);
    wait_rd();
    step();
    send_byte(8'h41, 1'b0, 1'b1);
    send_byte(8'h42, 1'b0, 1'b1);
    stop = 1'b1; step(); stop = 1'b0;
    send_byte(8'h43, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    chk("t3_busy_abort", 64'(busy), 1);
    pulse_done();
    chk("t3_idle", 64'(busy), 0);
    step(); step();
    chk("t3_no_song_done", 64'(done_count - d0), 0);
    chk("t3_writes", 64'(wr_count - w0), 2);
    addr_q.push_back(32'h300);
    start_song(32'h300, 24'd1);
    chk("t3_restart_busy", 64'(busy), 1);
    run_block(4, 8'h50);
    wait_song_done();
    step();

    // 4: overflow and short block
    w0 = wr_count;
    addr_q.push_back(32'h400); addr_q.push_back(32'h401);
    start_song(32'h400, 24'd2);
    wait_rd();
    step();
    send_byte(8'h61, 1'b0, 1'b1);
    send_byte(8'h62, 1'b0, 1'b1);
    send_byte(8'h63, 1'b1, 1'b0);
    chk("t4_overflow_set", 64'(overflow_err), 1);
    send_byte(8'h64, 1'b0, 1'b1);
    pulse_done();
    chk("t4_no_len_err", 64'(len_err), 0);
    run_block(3, 8'h70);
    chk("t4_len_err", 64'(len_err), 1);
    wait_song_done();
    step();
    chk("t4_writes", 64'(wr_count - w0), 6);
    chk("t4_sticky", 64'({overflow_err, len_err}), 64'b11);

    // 5: zero-length song and address wrap
    r0 = rd_count; d0 = done_count;
    start_song(32'h0, 24'd0);
    chk("t5_errs_cleared", 64'({overflow_err, len_err}), 0);
    wait_song_done();
    step(); step();
    chk("t5_done_once", 64'(done_count - d0), 1);
    chk("t5_no_rd", 64'(rd_count - r0), 0);
    chk("t5_idle", 64'(busy), 0);
    addr_q.push_back(32'hFFFF_FFFF); addr_q.push_back(32'h0000_0000);
    start_song(32'hFFFF_FFFF, 24'd2);
    run_block(4, 8'h80);
    run_block(4, 8'h90);
    wait_song_done();
    step();
    chk("t5_addr_drained", 64'(addr_q.size()), 0);

    // 6: asynchronous reset mid-stream
    addr_q.push_back(32'h500);
    start_song(32'h500, 24'd1);
    wait_rd();
    step();
    send_byte(8'hA5, 1'b0, 1'b1);
    @(negedge clk); #1;
    rst = 1'b0;
    wr_exp = 1'b0;
    #1;
    chk("t6_sd_addr", 64'(sd_addr), 0);
    chk("t6_fifo_din", 64'(fifo_din), 0);
    chk("t6_fifo_wr", 64'(fifo_wr), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_flags", 64'({sd_rd, song_done, overflow_err, len_err}), 0);
    byte_q.delete();
    addr_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    w0 = wr_count;
    send_byte(8'hB6, 1'b0, 1'b0);
    pulse_done();
    step(); step();
    chk("t6_stray_ignored", 64'(wr_count - w0), 0);
    chk("t6_still_idle", 64'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
